// File: rtl/bcd_to_binary_reader.sv
// bcd_to_binary_reader: multi-cycle reverse double-dabble BCD-to-binary converter with start/busy/done handshake
module bcd_to_binary_reader #(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [OUT_W-1:0]      binary_out
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [2*W-1:0] sr_q, sr_d, step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, err_q, err_d, bad;
  logic [OUT_W-1:0] out_q, out_d;
  if (OUT_W < W) begin : g_chk
    $error("OUT_W must be >= 4*DIGITS");
  end
  always_comb begin
    step = sr_q >> 1;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      step[W+4*i +: 4] = step[W+4*i +: 4] >= 4'd8 ? step[W+4*i +: 4] - 4'd3 : step[W+4*i +: 4];
      bad = bad | (bcd_in[4*i +: 4] > 4'd9);
    end
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    err_d = err_q;
    out_d = out_q;
    case (state_q)
      IDLE: if (start) begin
        sr_d = {bcd_in, {W{1'b0}}};
        cnt_d = bad ? CW'(1) : CW'(W);
        pend_d = bad;
        state_d = SHIFT;
      end
      SHIFT: begin
        sr_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          out_d = pend_q ? '0 : OUT_W'(step[W-1:0]);
          err_d = pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      err_q <= err_d;
      out_q <= out_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign error = err_q;
  assign binary_out = out_q;
endmodule

// File: tb/tb_bcd_to_binary_reader.sv
// tb_bcd_to_binary_reader: directed self-checking bench for bcd_to_binary_reader
module tb_bcd_to_binary_reader;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [11:0] bcd_in = '0;
  logic busy, done, error;
  logic [31:0] binary_out;
  int errs = 0;
  int checks = 0;
  bcd_to_binary_reader #(.DIGITS(3), .OUT_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .bcd_in(bcd_in),
    .busy(busy),
    .done(done),
    .error(error),
    .binary_out(binary_out)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [11:0] b);
    @(negedge clock);
    bcd_in = b;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask
  task automatic watch(output int first, output int nd, output int nb);
    first = -1;
    nd = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy) nb++;
      if (done) begin
        nd++;
        if (first < 0) first = i;
      end
      if (!busy) break;
    end
  endtask
  task automatic conv(input string tag, input logic [11:0] b, input logic [31:0] eo, input logic ee, input int lat);
    int f, nd, nb;
    launch(b);
    watch(f, nd, nb);
    check({tag, " latency"}, f, lat);
    check({tag, " ndone"}, nd, 1);
    check({tag, " busy_cycles"}, nb, lat + 1);
    check({tag, " out"}, binary_out, eo);
    check({tag, " err"}, error, ee);
  endtask
  initial begin
    int f, nd, nb;
    int idx[$];
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", error, 0);
    check("rst out", binary_out, 0);
    conv("c255", 12'h255, 32'h0000_00FF, 1'b0, 12);
    conv("c999", 12'h999, 32'h0000_03E7, 1'b0, 12);
    repeat (3) @(negedge clock);
    check("hold out", binary_out, 32'h0000_03E7);
    check("hold done", done, 0);
    conv("c000", 12'h000, 32'h0, 1'b0, 12);
    conv("c1A5", 12'h1A5, 32'h0, 1'b1, 1);
    conv("c010", 12'h010, 32'h0000_000A, 1'b0, 12);
    launch(12'h123);
    repeat (4) @(posedge clock);
    launch(12'h456);
    watch(f, nd, nb);
    check("ign latency", f, 7);
    check("ign ndone", nd, 1);
    check("ign out", binary_out, 32'h0000_007B);
    check("ign err", error, 0);
    repeat (20) @(negedge clock);
    check("ign no_restart", busy, 0);
    launch(12'h777);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("abort ndone", nd, 0);
    check("abort busy", busy, 0);
    check("abort out", binary_out, 0);
    check("abort err", error, 0);
    conv("c042", 12'h042, 32'h0000_002A, 1'b0, 12);
    @(negedge clock);
    bcd_in = 12'h100;
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (done) begin
        idx.push_back(i);
        check("cont out", binary_out, 32'h0000_0064);
      end
    end
    start = 1'b0;
    check("cont npulses", idx.size(), 3);
    if (idx.size() == 3) begin
      check("cont first", idx[0], 12);
      check("cont gap1", idx[1] - idx[0], 14);
      check("cont gap2", idx[2] - idx[1], 14);
    end
    nb = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      @(negedge clock);
      nb++;
    end
    check("cont drain", busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
